// File: rtl/csr_bus_arbiter.sv
// Two-master CSR bus arbiter: captured pulse master (s0) and stallable master (s1) share one target bus.
// Define CSR_BUS_ARBITER_S0_PRIORITY_EN for fixed s0 priority; otherwise ties are round-robin.
module csr_bus_arbiter #(
   parameter int A_WIDTH    = 5,
   parameter int RD_LATENCY = 1
) (
   input  logic               clk,
   input  logic               reset,

   input  logic [A_WIDTH-1:0] s0_address,
   input  logic               s0_read,
   input  logic               s0_write,
   input  logic [7:0]         s0_writedata,
   output logic [7:0]         s0_readdata,
   output logic               s0_overrun,

   input  logic [A_WIDTH-1:0] s1_address,
   input  logic               s1_read,
   input  logic               s1_write,
   input  logic [7:0]         s1_writedata,
   output logic               s1_waitrequest,
   output logic [7:0]         s1_readdata,
   output logic               s1_readdatavalid,

   output logic [A_WIDTH-1:0] m_address,
   output logic               m_read,
   output logic               m_write,
   output logic [7:0]         m_writedata,
   input  logic [7:0]         m_readdata
);

   // state | meaning
   // IDLE  | no transaction on the target bus; arbitrate
   // ISSUE | one-cycle m_read/m_write strobe for the granted port
   // WAIT  | read in flight; count down to the read-data cycle
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [1:0] CNT_INIT = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

   state_t               state_q;
   logic                 grant_q;
   logic                 last_grant_q;
   logic [1:0]           cnt_q;

   logic                 pend0_q,     pend0_d;
   logic [A_WIDTH-1:0]   p0_addr_q,   p0_addr_d;
   logic [7:0]           p0_data_q,   p0_data_d;
   logic                 p0_wr_q,     p0_wr_d;
   logic                 s0_overrun_q, s0_overrun_d;

   logic [7:0]           s0_readdata_q;
   logic [7:0]           s1_readdata_q;
   logic                 s1_rdv_q;

   logic                 s0_req;
   logic                 s1_req;
   logic                 consume0;
   logic                 issuing;
   logic                 issue_wr;
   logic                 pick_s1;

   assign s0_req   = s0_read | s0_write;
   assign s1_req   = s1_read | s1_write;
   assign issuing  = (state_q == ISSUE);
   assign consume0 = issuing & ~grant_q;
   assign issue_wr = grant_q ? s1_write : p0_wr_q;

   // A new pulse always wins over the held request; it only counts as an
   // overrun if the held one was not being issued in the same cycle.
   always_comb begin
      pend0_d      = pend0_q;
      p0_addr_d    = p0_addr_q;
      p0_data_d    = p0_data_q;
      p0_wr_d      = p0_wr_q;
      s0_overrun_d = s0_overrun_q;
      if (s0_req) begin
         pend0_d   = 1'b1;
         p0_addr_d = s0_address;
         p0_data_d = s0_writedata;
         p0_wr_d   = s0_write;
         if (pend0_q && !consume0) begin
            s0_overrun_d = 1'b1;
         end
      end else if (consume0) begin
         pend0_d = 1'b0;
      end
   end

   always_comb begin
      pick_s1 = s1_req;
      if (pend0_q && s1_req) begin
`ifdef CSR_BUS_ARBITER_S0_PRIORITY_EN
         pick_s1 = 1'b0;
`else
         pick_s1 = ~last_grant_q;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         cnt_q         <= 2'd0;
         pend0_q       <= 1'b0;
         p0_addr_q     <= '0;
         p0_data_q     <= 8'd0;
         p0_wr_q       <= 1'b0;
         s0_overrun_q  <= 1'b0;
         s0_readdata_q <= 8'd0;
         s1_readdata_q <= 8'd0;
         s1_rdv_q      <= 1'b0;
      end else begin
         pend0_q      <= pend0_d;
         p0_addr_q    <= p0_addr_d;
         p0_data_q    <= p0_data_d;
         p0_wr_q      <= p0_wr_d;
         s0_overrun_q <= s0_overrun_d;
         s1_rdv_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pend0_q || s1_req) begin
                  grant_q      <= pick_s1;
                  last_grant_q <= pick_s1;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               if (issue_wr) begin
                  state_q <= IDLE;
               end else if (RD_LATENCY == 0) begin
                  if (grant_q) begin
                     s1_readdata_q <= m_readdata;
                     s1_rdv_q      <= 1'b1;
                  end else begin
                     s0_readdata_q <= m_readdata;
                  end
                  state_q <= IDLE;
               end else begin
                  cnt_q   <= CNT_INIT;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == 2'd0) begin
                  if (grant_q) begin
                     s1_readdata_q <= m_readdata;
                     s1_rdv_q      <= 1'b1;
                  end else begin
                     s0_readdata_q <= m_readdata;
                  end
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m_read      = issuing & ~issue_wr;
   assign m_write     = issuing & issue_wr;
   assign m_address   = issuing ? (grant_q ? s1_address   : p0_addr_q) : '0;
   assign m_writedata = issuing ? (grant_q ? s1_writedata : p0_data_q) : 8'd0;

   assign s1_waitrequest   = ~(issuing & grant_q);
   assign s1_readdata      = s1_readdata_q;
   assign s1_readdatavalid = s1_rdv_q;
   assign s0_readdata      = s0_readdata_q;
   assign s0_overrun       = s0_overrun_q;

endmodule

// File: doc/csr_bus_arbiter.md
Name: csr_bus_arbiter

Overview:
- Shares one 8-bit CSR register bus between two masters.
- Port s0 is a fire-and-forget pulse master, such as the SPI slave's resynchronised csr_read/csr_write events. Its requests are captured and its read data is held in a register.
- Port s1 is a stallable local master using a waitrequest/readdatavalid handshake, such as an MCU bridge or a test sequencer.
- Sits between both masters and the CSR target (e.g. the cdbus controller); one transaction runs on the target bus at a time.

Parameters:
A_WIDTH, 5, CSR address width.
RD_LATENCY, 1, cycles from m_read to valid m_readdata; legal range 0..3.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous active-high reset.
s0_address  input  A_WIDTH  s0 address, valid with a pulse.
s0_read  input  1  one-cycle read event.
s0_write  input  1  one-cycle write event.
s0_writedata  input  8  s0 write data, valid with s0_write.
s0_readdata  output  8  last s0 read result, held until the next s0 read completes.
s0_overrun  output  1  sticky flag: a pending s0 request was overwritten before being granted.
s1_address  input  A_WIDTH  s1 address.
s1_read  input  1  s1 read request, held until accepted.
s1_write  input  1  s1 write request, held until accepted.
s1_writedata  input  8  s1 write data.
s1_waitrequest  output  1  low for exactly the cycle in which the s1 request is accepted.
s1_readdata  output  8  s1 read data, valid with s1_readdatavalid.
s1_readdatavalid  output  1  one-cycle strobe.
m_address  output  A_WIDTH  target address.
m_read  output  1  target read strobe, one cycle.
m_write  output  1  target write strobe, one cycle.
m_writedata  output  8  target write data.
m_readdata  input  8  target read data, valid RD_LATENCY cycles after m_read.

Behaviour:
- Reset values: all registers clear, state=IDLE, last_grant=1.
  - Outputs in reset: m_read=0, m_write=0, m_address=0, m_writedata=0, s0_readdata=0, s0_overrun=0, s1_readdata=0, s1_readdatavalid=0, s1_waitrequest=1.
  - Reset mid-transaction aborts it: the pending s0 request is dropped and no readdatavalid is issued.
- s0 capture:
  - Any s0_read or s0_write pulse latches address, data and opcode into p0 registers and sets pend0 on the next edge.
  - Both strobes high in the same cycle: treated as a write.
  - Pulse while pend0=1 and not being consumed this cycle: the new request overwrites the old one and s0_overrun is set.
  - Pulse in the same cycle pend0 is consumed (ISSUE granted to s0): the new request is captured, pend0 stays 1, no overrun.
- Arbitration (IDLE only):
  - Requesters are pend0 and (s1_read|s1_write).
  - A single requester wins.
  - When both request, round-robin: the port not equal to last_grant wins.
  - On a grant: grant and last_grant are updated, state<=ISSUE.
- State machine: IDLE -> ISSUE -> (WAIT) -> IDLE.
  - ISSUE, outputs: m_* are driven combinationally from the granted port (p0 regs or live s1 inputs); m_read/m_write are high for exactly this cycle. s1_waitrequest=0 here only if grant=1. pend0 clears here if grant=0, unless a new pulse arrives this cycle.
  - ISSUE, next state: a write goes to IDLE. A read with RD_LATENCY=0 captures m_readdata now and goes to IDLE. A read with RD_LATENCY>0 loads cnt=RD_LATENCY-1 and goes to WAIT.
  - WAIT: cnt decrements each cycle. At cnt==0, m_readdata is captured into s0_readdata or s1_readdata and the state goes to IDLE. If grant=1, s1_readdatavalid pulses on the following cycle.
- Latency:
  - s0 pulse at cycle T gives m_* at T+2; s0_readdata updates at T+3+RD_LATENCY.
  - s1 accepted at cycle X gives s1_readdatavalid at X+1+RD_LATENCY.
  - Bus occupancy: a write takes 2 cycles including IDLE; a read takes 2+RD_LATENCY.
- s1 read and write both high: treated as a write.
- s1 dropping its request before acceptance is illegal (protocol violation); no required behaviour.
- s0_readdata and s0_overrun change only as specified above.

Optional Feature:
CSR_BUS_ARBITER_S0_PRIORITY_EN:
- Defined: fixed priority; pend0 always wins ties, so SPI traffic never waits behind s1. last_grant is still updated but unused.
- Undefined: round-robin as above.

Test Plan:
- RD_LATENCY=1, s0_write addr=0x03 data=0xA5 pulse at T -> m_write=1, m_address=0x03, m_writedata=0xA5 at T+2 only; s0_overrun=0.
- s0_read addr=0x10, target returns 0x5C -> m_read at T+2; s0_readdata=0x5C from T+4 and held until the next s0 read.
- s1_read addr=0x07 held while idle, target returns 0x3E -> s1_waitrequest low for 1 cycle (X); s1_readdatavalid=1 with s1_readdata=0x3E at X+2.
- pend0 and s1 requesting continuously -> grants alternate s0,s1,s0,s1 (s0 first after reset). With CSR_BUS_ARBITER_S0_PRIORITY_EN: s0 is granted whenever pend0=1.
- Two s0_write pulses 1 cycle apart while s1 holds the bus in WAIT -> only the second is issued; s0_overrun=1 and remains 1 until reset.
- reset asserted during WAIT of an s1 read -> no s1_readdatavalid; all outputs at reset values the next cycle; pend0=0.
